// File: rtl/event_capture_pkg.sv
// Shared types, default widths and bit-level helpers for the event-capture path.
package event_capture_pkg;

   localparam int DEF_INPUT_WORD_SIZE = 32'sd32;
   localparam int DEF_NUM_INPUTS      = 32'sd5;
   localparam int DEF_OUTPUT_WORDS    = 32'sd2;
   localparam int DEF_DEPTH_BITS      = 32'sd5;
   localparam int MAX_LANES           = 32'sd32;

   function automatic int clog2(input int value);
      int r;
      r = 32'sd0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 << i) < value) begin
            r = i + 32'sd1;
         end
      end
      return r;
   endfunction

   localparam int CNT_BITS = clog2(MAX_LANES + 32'sd1);

   function automatic logic [CNT_BITS-1:0] popcount(input logic [MAX_LANES-1:0] v);
      logic [CNT_BITS-1:0] c;
      c = '0;
      for (int i = 0; i < MAX_LANES; i++) begin
         c = c + CNT_BITS'(v[i]);
      end
      return c;
   endfunction

   // Thermometer masks (bits 0..n-1 set) are exactly those where v+1 clears every set bit.
   function automatic logic is_thermometer(input logic [MAX_LANES-1:0] v);
      return ((v & (v + MAX_LANES'(1))) == '0);
   endfunction

endpackage

// File: rtl/wide_port_fifo_ram.sv
// Circular word storage: NUM_INPUTS write lanes and OUTPUT_WORDS read lanes,
// each lane addressed at base + lane index modulo the depth.
module wide_port_fifo_ram
   import event_capture_pkg::*;
#(
   parameter int WORD_SIZE  = DEF_INPUT_WORD_SIZE,
   parameter int WR_LANES   = DEF_NUM_INPUTS,
   parameter int RD_LANES   = DEF_OUTPUT_WORDS,
   parameter int ADDR_BITS  = DEF_DEPTH_BITS
) (
   input  logic                          clk,
   input  logic [ADDR_BITS-1:0]          wr_base,
   input  logic [WR_LANES-1:0]           wr_lane_en,
   input  logic [WORD_SIZE*WR_LANES-1:0] wr_data,
   input  logic [ADDR_BITS-1:0]          rd_base,
   output logic [WORD_SIZE*RD_LANES-1:0] rd_data
);

   localparam int DEPTH = 32'sd1 << ADDR_BITS;

   logic [WORD_SIZE-1:0] mem_r [DEPTH];

   // Lane writes; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      for (int j = 0; j < WR_LANES; j++) begin
         if (wr_lane_en[j]) begin
            mem_r[wr_base + ADDR_BITS'(j)] <= wr_data[WORD_SIZE*j +: WORD_SIZE];
         end
      end
   end

   // Fall-through read: the oldest word lands in the most-significant slice.
   always_comb begin
      rd_data = '0;
      for (int k = 0; k < RD_LANES; k++) begin
         rd_data[WORD_SIZE*(RD_LANES-1-k) +: WORD_SIZE] = mem_r[rd_base + ADDR_BITS'(k)];
      end
   end

endmodule

// File: rtl/wide_port_fifo.sv
// Multi-lane-write, wide-read FIFO with occupancy, flush and one-cycle error pulses.
module wide_port_fifo
   import event_capture_pkg::*;
#(
   parameter int INPUT_WORD_SIZE = DEF_INPUT_WORD_SIZE,
   parameter int NUM_INPUTS      = DEF_NUM_INPUTS,
   parameter int OUTPUT_WORDS    = DEF_OUTPUT_WORDS,
   parameter int DEPTH_BITS      = DEF_DEPTH_BITS
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [INPUT_WORD_SIZE*NUM_INPUTS-1:0] d_in,
   input  logic [NUM_INPUTS-1:0]                wr_en,
   input  logic                                 rd_en,
   input  logic                                 flush,
   output logic [OUTPUT_WORDS*INPUT_WORD_SIZE-1:0] d_out,
   output logic                                 out_valid,
   output logic [DEPTH_BITS:0]                  word_count,
   output logic                                 full,
   output logic                                 empty,
   output logic                                 overflow,
   output logic                                 underflow,
   output logic                                 wr_mask_err
);

   localparam int DEPTH = 32'sd1 << DEPTH_BITS;
   localparam int CW    = DEPTH_BITS + 32'sd1;

   logic [DEPTH_BITS-1:0] wr_ptr_r, wr_ptr_s;
   logic [DEPTH_BITS-1:0] rd_ptr_r, rd_ptr_s;
   logic [CW-1:0]         count_r, count_s;
   logic [CW-1:0]         n_s, free_s;
   logic                  overflow_r, overflow_s;
   logic                  underflow_r, underflow_s;
   logic                  mask_err_r, mask_err_s;
   logic                  mask_ok_s, wr_ok_s, rd_ok_s;
   logic [NUM_INPUTS-1:0] lane_en_s;
   logic [MAX_LANES-1:0]  wr_en_ext_s;

   assign wr_en_ext_s = MAX_LANES'(wr_en);

   // Acceptance decisions and next state; space is judged against the pre-read count.
   always_comb begin
      n_s         = CW'(popcount(wr_en_ext_s));
      free_s      = CW'(DEPTH) - count_r;
      mask_ok_s   = is_thermometer(wr_en_ext_s);
      wr_ok_s     = mask_ok_s && (n_s <= free_s);
      rd_ok_s     = rd_en && out_valid;
      wr_ptr_s    = wr_ptr_r;
      rd_ptr_s    = rd_ptr_r;
      count_s     = count_r;
      overflow_s  = 1'b0;
      underflow_s = 1'b0;
      mask_err_s  = 1'b0;
      lane_en_s   = '0;
      if (flush) begin
         wr_ptr_s = '0;
         rd_ptr_s = '0;
         count_s  = '0;
      end else begin
         if (wr_ok_s) begin
            wr_ptr_s  = wr_ptr_r + n_s[DEPTH_BITS-1:0];
            lane_en_s = rst ? '0 : wr_en;
         end else begin
            wr_ptr_s  = wr_ptr_r;
         end
         if (rd_ok_s) begin
            rd_ptr_s = rd_ptr_r + DEPTH_BITS'(OUTPUT_WORDS);
         end else begin
            rd_ptr_s = rd_ptr_r;
         end
         count_s     = count_r + (wr_ok_s ? n_s : '0) - (rd_ok_s ? CW'(OUTPUT_WORDS) : '0);
         overflow_s  = mask_ok_s && !wr_ok_s;
         underflow_s = rd_en && !out_valid;
         mask_err_s  = !mask_ok_s;
      end
   end

   // State and error-pulse registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         count_r     <= '0;
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
         mask_err_r  <= 1'b0;
      end else begin
         wr_ptr_r    <= wr_ptr_s;
         rd_ptr_r    <= rd_ptr_s;
         count_r     <= count_s;
         overflow_r  <= overflow_s;
         underflow_r <= underflow_s;
         mask_err_r  <= mask_err_s;
      end
   end

   wide_port_fifo_ram #(
      .WORD_SIZE (INPUT_WORD_SIZE),
      .WR_LANES  (NUM_INPUTS),
      .RD_LANES  (OUTPUT_WORDS),
      .ADDR_BITS (DEPTH_BITS)
   ) u_ram (
      .clk        (clk),
      .wr_base    (wr_ptr_r),
      .wr_lane_en (lane_en_s),
      .wr_data    (d_in),
      .rd_base    (rd_ptr_r),
      .rd_data    (d_out)
   );

   assign word_count  = count_r;
   assign out_valid   = count_r >= CW'(OUTPUT_WORDS);
   assign full        = free_s < CW'(NUM_INPUTS);
   assign empty       = count_r == '0;
   assign overflow    = overflow_r;
   assign underflow   = underflow_r;
   assign wr_mask_err = mask_err_r;

endmodule

// File: tb/tb_wide_port_fifo.sv
// Randomised bench for wide_port_fifo against a queue-based reference model.
module tb_wide_port_fifo;

   logic         clk;
   logic         rst;
   logic [159:0] d_in;
   logic [4:0]   wr_en;
   logic         rd_en;
   logic         flush;
   logic [63:0]  d_out;
   logic         out_valid;
   logic [5:0]   word_count;
   logic         full;
   logic         empty;
   logic         overflow;
   logic         underflow;
   logic         wr_mask_err;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] q[$];
   bit exp_ovf, exp_unf, exp_mask;

   wide_port_fifo dut (
      .clk(clk), .rst(rst), .d_in(d_in), .wr_en(wr_en), .rd_en(rd_en), .flush(flush),
      .d_out(d_out), .out_valid(out_valid), .word_count(word_count), .full(full),
      .empty(empty), .overflow(overflow), .underflow(underflow), .wr_mask_err(wr_mask_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [159:0] lanes(input logic [31:0] base);
      logic [159:0] d;
      for (int j = 0; j < 5; j++) d[32*j +: 32] = base + 32'(j);
      return d;
   endfunction

   function automatic logic [159:0] rnd_lanes();
      logic [159:0] d;
      for (int j = 0; j < 5; j++) d[32*j +: 32] = $urandom;
      return d;
   endfunction

   function automatic logic [4:0] therm(input int n);
      logic [5:0] t;
      t = (6'd1 << n) - 6'd1;
      return t[4:0];
   endfunction

   task automatic model_check();
      int sz;
      sz = q.size();
      chk("word_count", 64'(word_count), 64'(sz));
      chk("out_valid", 64'(out_valid), 64'(sz >= 2));
      chk("full", 64'(full), 64'((32 - sz) < 5));
      chk("empty", 64'(empty), 64'(sz == 0));
      chk("overflow", 64'(overflow), 64'(exp_ovf));
      chk("underflow", 64'(underflow), 64'(exp_unf));
      chk("wr_mask_err", 64'(wr_mask_err), 64'(exp_mask));
      if (sz >= 2) chk("d_out", d_out, {q[0], q[1]});
   endtask

   // Apply one cycle of stimulus, advance the model from the pre-edge state, then compare.
   task automatic cycle(input logic [4:0] we, input logic [159:0] d, input bit re,
                        input bit fl, input bit rs);
      int  n, sz;
      bit  thermo, seen_zero;
      wr_en = we; d_in = d; rd_en = re; flush = fl; rst = rs;
      n = 0; thermo = 1'b1; seen_zero = 1'b0;
      for (int j = 0; j < 5; j++) begin
         if (we[j]) begin
            n++;
            if (seen_zero) thermo = 1'b0;
         end else begin
            seen_zero = 1'b1;
         end
      end
      exp_ovf = 1'b0; exp_unf = 1'b0; exp_mask = 1'b0;
      if (rs || fl) begin
         q.delete();
      end else begin
         sz = q.size();
         if (!thermo) exp_mask = 1'b1;
         else if (n > 32 - sz) exp_ovf = 1'b1;
         if (re && sz < 2) exp_unf = 1'b1;
         if (re && sz >= 2) begin
            void'(q.pop_front());
            void'(q.pop_front());
         end
         if (thermo && !exp_ovf)
            for (int j = 0; j < n; j++) q.push_back(d[32*j +: 32]);
      end
      @(posedge clk);
      #1;
      model_check();
      wr_en = '0; rd_en = 1'b0; flush = 1'b0; rst = 1'b0;
   endtask

   initial begin
      logic [4:0] we;
      wr_en = '0; d_in = '0; rd_en = 1'b0; flush = 1'b0; rst = 1'b1;
      @(posedge clk); #1;

      // Basic write of three lanes then a pop.
      cycle(5'b00000, '0, 1'b0, 1'b0, 1'b1);
      chk("t1_reset_count", 64'(word_count), 64'd0);
      chk("t1_reset_empty", 64'(empty), 64'd1);
      chk("t1_reset_full", 64'(full), 64'd0);
      cycle(5'b00111, lanes(32'hA000_0000), 1'b0, 1'b0, 1'b0);
      chk("t1_count", 64'(word_count), 64'd3);
      chk("t1_dout", d_out, 64'hA000_0000_A000_0001);
      cycle(5'b00000, '0, 1'b1, 1'b0, 1'b0);
      chk("t1_pop_count", 64'(word_count), 64'd1);
      chk("t1_pop_valid", 64'(out_valid), 64'd0);

      // Drive the write pointer to 30, drain, then write across the wrap.
      cycle(5'b00000, '0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) cycle(therm(5), rnd_lanes(), 1'b1, 1'b0, 1'b0);
      chk("t2_pre_count", 64'(word_count), 64'd20);
      for (int i = 0; i < 10; i++) cycle('0, '0, 1'b1, 1'b0, 1'b0);
      cycle(therm(3), lanes(32'hB000_0000), 1'b0, 1'b0, 1'b0);
      chk("t2_dout0", d_out, 64'hB000_0000_B000_0001);
      cycle('0, '0, 1'b1, 1'b0, 1'b0);
      cycle(therm(1), lanes(32'hC000_0000), 1'b0, 1'b0, 1'b0);
      chk("t2_dout1", d_out, 64'hB000_0002_C000_0000);

      // Overflow at 29 words, then an exact fill.
      cycle('0, '0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) cycle(therm(5), rnd_lanes(), 1'b0, 1'b0, 1'b0);
      cycle(therm(4), rnd_lanes(), 1'b0, 1'b0, 1'b0);
      cycle(therm(4), rnd_lanes(), 1'b0, 1'b0, 1'b0);
      chk("t3_ovf", 64'(overflow), 64'd1);
      chk("t3_count", 64'(word_count), 64'd29);
      chk("t3_full", 64'(full), 64'd1);
      cycle(therm(3), rnd_lanes(), 1'b0, 1'b0, 1'b0);
      chk("t3_fill_count", 64'(word_count), 64'd32);
      chk("t3_fill_ovf", 64'(overflow), 64'd0);

      // Non-thermometer mask while full: mask error only.
      cycle(5'b01010, rnd_lanes(), 1'b0, 1'b0, 1'b0);
      chk("t4_mask", 64'(wr_mask_err), 64'd1);
      chk("t4_ovf", 64'(overflow), 64'd0);
      chk("t4_count", 64'(word_count), 64'd32);

      // Underflow with one word, then read plus write in one cycle.
      cycle('0, '0, 1'b0, 1'b0, 1'b1);
      cycle(therm(1), rnd_lanes(), 1'b0, 1'b0, 1'b0);
      cycle('0, '0, 1'b1, 1'b0, 1'b0);
      chk("t5_unf", 64'(underflow), 64'd1);
      chk("t5_count", 64'(word_count), 64'd1);
      cycle(therm(1), rnd_lanes(), 1'b0, 1'b0, 1'b0);
      cycle(therm(3), rnd_lanes(), 1'b1, 1'b0, 1'b0);
      chk("t5_rw_count", 64'(word_count), 64'd3);

      // Flush and reset mid-stream at 17 words, each with traffic active.
      for (int pass = 0; pass < 2; pass++) begin
         cycle('0, '0, 1'b0, 1'b0, 1'b1);
         for (int i = 0; i < 3; i++) cycle(therm(5), rnd_lanes(), 1'b0, 1'b0, 1'b0);
         cycle(therm(2), rnd_lanes(), 1'b0, 1'b0, 1'b0);
         chk("t6_pre_count", 64'(word_count), 64'd17);
         cycle(therm(5), rnd_lanes(), 1'b1, pass == 0, pass == 1);
         chk("t6_count", 64'(word_count), 64'd0);
         chk("t6_empty", 64'(empty), 64'd1);
         chk("t6_errs", 64'({overflow, underflow, wr_mask_err}), 64'd0);
      end
      cycle(5'b10001, rnd_lanes(), 1'b1, 1'b1, 1'b0);
      chk("t6_flush_err", 64'({underflow, wr_mask_err}), 64'd0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(99) < 85) we = therm(int'($urandom_range(5)));
         else we = 5'($urandom);
         cycle(we, rnd_lanes(), $urandom_range(1) == 1, $urandom_range(199) == 0,
               $urandom_range(299) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
